// File: rtl/ucd_digital_pkg.sv
// Shared definitions for the ucd digital datapath blocks: select encodings,
// default widths and the per-slot occupancy state.
package ucd_digital_pkg;

    localparam logic SEL_OUT0 = 1'b0;
    localparam logic SEL_OUT1 = 1'b1;

    localparam int unsigned DEFAULT_WIDTH     = 32;
    localparam int unsigned DEFAULT_CNT_WIDTH = 8;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/demux_1to2_32bit_reg_slot.sv
// One output slot of the registered demux: single-entry holding register,
// valid flag, ready term towards the producer and a wrapping delivery counter.
module demux_slot
    import ucd_digital_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [WIDTH-1:0]     din,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     dout,
    output logic                 valid,
    output logic                 slot_ready,
    output logic [CNT_WIDTH-1:0] count
);

    slot_state_e state_q, state_d;
    logic        deliver;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SLOT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // A load always wins over a drain, so load+deliver stays FULL.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SLOT_EMPTY: if (load) state_d = SLOT_FULL;
            SLOT_FULL: begin
                if (load) begin
                    state_d = SLOT_FULL;
                end else if (out_ready) begin
                    state_d = SLOT_EMPTY;
                end
            end
        endcase
    end

    always_comb begin
        valid      = (state_q == SLOT_FULL);
        deliver    = valid & out_ready;
        slot_ready = ~valid | out_ready;
    end

    // Data is not cleared on drain; it keeps the last delivered word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= '0;
        end else if (load) begin
            dout <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (deliver) begin
            count <= count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/demux_1to2_32bit_reg.sv
// Registered 1-to-2 demultiplexer: steers the input stream to one of two
// independently stalling output slots according to Select.
module demux_1to2_32bit_reg
    import ucd_digital_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
    input  logic                 Clock,
    input  logic                 Reset_n,
    input  logic [WIDTH-1:0]     In,
    input  logic                 In_Valid,
    input  logic                 Select,
    output logic                 In_Ready,
    output logic [WIDTH-1:0]     Out0,
    output logic                 Out0_Valid,
    input  logic                 Out0_Ready,
    output logic [WIDTH-1:0]     Out1,
    output logic                 Out1_Valid,
    input  logic                 Out1_Ready,
    output logic [CNT_WIDTH-1:0] Count0,
    output logic [CNT_WIDTH-1:0] Count1
);

    logic             load0, load1;
    logic             ready0, ready1;
    logic [WIDTH-1:0] din;

    // An unknown Select loads unknown data into both slots, like the mux's default arm.
    always_comb begin
        load0    = 1'b0;
        load1    = 1'b0;
        din      = In;
        In_Ready = 1'b0;
        case (Select)
            SEL_OUT0: begin
                In_Ready = ready0;
                load0    = In_Valid & ready0;
            end
            SEL_OUT1: begin
                In_Ready = ready1;
                load1    = In_Valid & ready1;
            end
            default: begin
                In_Ready = 1'bx;
                load0    = In_Valid;
                load1    = In_Valid;
                din      = 'x;
            end
        endcase
    end

    demux_slot #(
        .WIDTH    (WIDTH),
        .CNT_WIDTH(CNT_WIDTH)
    ) u_slot0 (
        .clk       (Clock),
        .rst_n     (Reset_n),
        .load      (load0),
        .din       (din),
        .out_ready (Out0_Ready),
        .dout      (Out0),
        .valid     (Out0_Valid),
        .slot_ready(ready0),
        .count     (Count0)
    );

    demux_slot #(
        .WIDTH    (WIDTH),
        .CNT_WIDTH(CNT_WIDTH)
    ) u_slot1 (
        .clk       (Clock),
        .rst_n     (Reset_n),
        .load      (load1),
        .din       (din),
        .out_ready (Out1_Ready),
        .dout      (Out1),
        .valid     (Out1_Valid),
        .slot_ready(ready1),
        .count     (Count1)
    );

endmodule

// File: tb/tb_demux_1to2_32bit_reg.sv
// Self-checking bench for demux_1to2_32bit_reg: directed vector table, hand
// sequences for reset/throughput/wrap, and random traffic against a model.
module tb_demux_1to2_32bit_reg;

    logic        Clock = 1'b0;
    logic        Reset_n;
    logic [31:0] In;
    logic        In_Valid;
    logic        Select;
    logic        In_Ready;
    logic [31:0] Out0, Out1;
    logic        Out0_Valid, Out1_Valid;
    logic        Out0_Ready, Out1_Ready;
    logic [7:0]  Count0, Count1;

    demux_1to2_32bit_reg #(
        .WIDTH    (32),
        .CNT_WIDTH(8)
    ) dut (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .In        (In),
        .In_Valid  (In_Valid),
        .Select    (Select),
        .In_Ready  (In_Ready),
        .Out0      (Out0),
        .Out0_Valid(Out0_Valid),
        .Out0_Ready(Out0_Ready),
        .Out1      (Out1),
        .Out1_Valid(Out1_Valid),
        .Out1_Ready(Out1_Ready),
        .Count0    (Count0),
        .Count1    (Count1)
    );

    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: each destination holds at most one word; counts are deliveries mod 256.
    bit          m_full [2];
    logic [31:0] m_data [2];
    int          m_cnt  [2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            m_full[k] = 1'b0;
            m_data[k] = '0;
            m_cnt[k]  = 0;
        end
    endtask

    task automatic check_model();
        chk("out0",   64'(Out0),       64'(m_data[0]));
        chk("v0",     64'(Out0_Valid), 64'(m_full[0]));
        chk("out1",   64'(Out1),       64'(m_data[1]));
        chk("v1",     64'(Out1_Valid), 64'(m_full[1]));
        chk("count0", 64'(Count0),     64'(m_cnt[0]));
        chk("count1", 64'(Count1),     64'(m_cnt[1]));
    endtask

    // Drive one cycle at the falling edge, sample ready, clock, update model.
    task automatic step(input logic [31:0] d, input logic v, input logic s,
                        input logic r0, input logic r1, input bit use_model,
                        output logic rdy_seen);
        bit rdy [2];
        bit exp_ready, acc;
        @(negedge Clock);
        In = d; In_Valid = v; Select = s; Out0_Ready = r0; Out1_Ready = r1;
        #1;
        rdy_seen  = In_Ready;
        rdy[0]    = r0;
        rdy[1]    = r1;
        exp_ready = !m_full[s] || rdy[s];
        if (use_model) chk("in_ready", 64'(In_Ready), 64'(exp_ready));
        acc = v && exp_ready;
        @(posedge Clock);
        for (int k = 0; k < 2; k++) begin
            if (m_full[k] && rdy[k]) begin
                m_cnt[k]  = (m_cnt[k] + 1) % 256;
                m_full[k] = 1'b0;
            end
            if (acc && int'(s) == k) begin
                m_data[k] = d;
                m_full[k] = 1'b1;
            end
        end
        #1;
        if (use_model) check_model();
    endtask

    task automatic do_reset();
        @(negedge Clock);
        Reset_n = 1'b0;
        In = '0; In_Valid = 1'b0; Select = 1'b0; Out0_Ready = 1'b0; Out1_Ready = 1'b0;
        model_clear();
        @(negedge Clock);
        @(negedge Clock);
        Reset_n = 1'b1;
    endtask

    typedef struct {
        logic [31:0] d;
        logic        v, s, r0, r1;
        logic        e_rdy;
        logic [31:0] e_out0;
        logic        e_v0;
        logic [31:0] e_out1;
        logic        e_v1;
        logic [7:0]  e_c0, e_c1;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic rs;
        logic [7:0] c1_before;

        vecs[0] = '{32'hDEADBEEF, 1, 1, 0, 0, 1, 32'h0,        0, 32'hDEADBEEF, 1, 8'd0, 8'd0};
        vecs[1] = '{32'h0,        0, 0, 0, 1, 1, 32'h0,        0, 32'hDEADBEEF, 0, 8'd0, 8'd1};
        vecs[2] = '{32'h11111111, 1, 0, 0, 0, 1, 32'h11111111, 1, 32'hDEADBEEF, 0, 8'd0, 8'd1};
        vecs[3] = '{32'h33333333, 1, 0, 0, 0, 0, 32'h11111111, 1, 32'hDEADBEEF, 0, 8'd0, 8'd1};
        vecs[4] = '{32'h22222222, 1, 1, 0, 0, 1, 32'h11111111, 1, 32'h22222222, 1, 8'd0, 8'd1};
        vecs[5] = '{32'hA5A5A5A5, 1, 1, 0, 1, 1, 32'h11111111, 1, 32'hA5A5A5A5, 1, 8'd0, 8'd2};
        vecs[6] = '{32'h5A5A5A5A, 1, 1, 0, 1, 1, 32'h11111111, 1, 32'h5A5A5A5A, 1, 8'd0, 8'd3};
        vecs[7] = '{32'h0,        0, 0, 1, 1, 1, 32'h11111111, 0, 32'h5A5A5A5A, 0, 8'd1, 8'd4};

        Reset_n = 1'b0;
        In = '0; In_Valid = 1'b0; Select = 1'b0; Out0_Ready = 1'b0; Out1_Ready = 1'b0;
        model_clear();
        #1;
        chk("rst_in_ready", 64'(In_Ready), 64'(1));
        check_model();
        @(negedge Clock);
        Reset_n = 1'b1;

        // Directed table: routing, independent stall, load+drain, drain.
        for (int i = 0; i < 8; i++) begin
            step(vecs[i].d, vecs[i].v, vecs[i].s, vecs[i].r0, vecs[i].r1, 1'b0, rs);
            chk($sformatf("vec%0d_in_ready", i), 64'(rs),         64'(vecs[i].e_rdy));
            chk($sformatf("vec%0d_out0", i),     64'(Out0),       64'(vecs[i].e_out0));
            chk($sformatf("vec%0d_v0", i),       64'(Out0_Valid), 64'(vecs[i].e_v0));
            chk($sformatf("vec%0d_out1", i),     64'(Out1),       64'(vecs[i].e_out1));
            chk($sformatf("vec%0d_v1", i),       64'(Out1_Valid), 64'(vecs[i].e_v1));
            chk($sformatf("vec%0d_c0", i),       64'(Count0),     64'(vecs[i].e_c0));
            chk($sformatf("vec%0d_c1", i),       64'(Count1),     64'(vecs[i].e_c1));
        end

        // Asynchronous reset mid-cycle with both slots full.
        do_reset();
        step(32'h11111111, 1, 0, 0, 0, 1'b1, rs);
        step(32'h22222222, 1, 1, 0, 0, 1'b1, rs);
        @(negedge Clock);
        In_Valid = 1'b0;
        #2;
        chk("pre_rst_v0", 64'(Out0_Valid), 64'(1));
        chk("pre_rst_v1", 64'(Out1_Valid), 64'(1));
        Reset_n = 1'b0;
        model_clear();
        #1;
        check_model();
        @(negedge Clock);
        Reset_n = 1'b1;

        // Back-to-back throughput on Out0.
        for (int i = 0; i < 8; i++) begin
            step(32'(i), 1, 0, 1, 0, 1'b1, rs);
            chk("b2b_in_ready", 64'(rs),   64'(1));
            chk("b2b_out0",     64'(Out0), 64'(i));
        end
        step(32'h0, 0, 0, 1, 0, 1'b1, rs);
        chk("b2b_count0", 64'(Count0), 64'(8));

        // Counter wrap on Out0; Count1 must not move.
        do_reset();
        for (int i = 0; i < 256; i++) step($urandom, 1, 0, 1, 0, 1'b1, rs);
        step(32'h0, 0, 0, 1, 0, 1'b1, rs);
        chk("wrap_count0", 64'(Count0), 64'(0));
        step(32'hCAFEF00D, 1, 0, 1, 0, 1'b1, rs);
        step(32'h0, 0, 0, 1, 0, 1'b1, rs);
        chk("wrap_count0_plus1", 64'(Count0), 64'(1));
        chk("wrap_count1",       64'(Count1), 64'(0));

        // Random traffic against the model.
        do_reset();
        c1_before = Count1;
        chk("rand_start_c1", 64'(c1_before), 64'(0));
        for (int i = 0; i < 2000; i++) begin
            step($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0), 1'b1, rs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_1to2_32bit_reg.md
Name: demux_1to2_32bit_reg

Overview:
- Registered 32-bit 1-to-2 demultiplexer. It is the distribution counterpart of mux_2to1_32bit.
- One input word stream is steered to Out0 or Out1 according to Select.
- Each output has a one-entry holding register and a valid/ready handshake, so the two consumers can stall independently.
- It sits between a single producer and two datapath consumers, for example splitting a result bus onto two register-file write ports.

Parameters:
- WIDTH, 32, data word width in bits.
- CNT_WIDTH, 8, width of the per-output transfer counters (wrap-around).

Ports:
- Clock  input  1  rising-edge clock for all state.
- Reset_n  input  1  asynchronous active-low reset; one clock, reset is asynchronous and active-low.
- In  input  WIDTH  input data word.
- In_Valid  input  1  In and Select are valid this cycle.
- Select  input  1  destination: 0 selects Out0, 1 selects Out1.
- In_Ready  output  1  the block accepts In this cycle.
- Out0  output  WIDTH  held word for destination 0.
- Out0_Valid  output  1  Out0 holds an undelivered word.
- Out0_Ready  input  1  consumer 0 takes Out0 this cycle.
- Out1  output  WIDTH  held word for destination 1.
- Out1_Valid  output  1  Out1 holds an undelivered word.
- Out1_Ready  input  1  consumer 1 takes Out1 this cycle.
- Count0  output  CNT_WIDTH  number of words delivered on Out0, modulo 2^CNT_WIDTH.
- Count1  output  CNT_WIDTH  number of words delivered on Out1, modulo 2^CNT_WIDTH.

Behaviour:
- Reset (Reset_n low, asynchronous):
  - Out0, Out1 = 0.
  - Out0_Valid, Out1_Valid = 0.
  - Count0, Count1 = 0.
  - In_Ready takes its combinational value (1 while both slots are empty).
- Slot k (k = 0 or 1) has two states:
  - EMPTY: Outk_Valid = 0.
  - FULL: Outk_Valid = 1.
- Transfer events:
  - Accept = In_Valid and In_Ready.
  - Deliver_k = Outk_Valid and Outk_Ready.
- In_Ready is combinational with no registered path: In_Ready = !Outk_Valid or Outk_Ready, where k = Select.
  - In_Ready depends only on the addressed slot.
  - A full, stalled slot never blocks traffic to the other slot.
- Slot k update at the clock edge:
  - Accept to k, slot EMPTY: load In; go FULL.
  - Accept to k and Deliver_k in the same cycle: load the new word; stay FULL. This gives full throughput of 1 word per clock.
  - Deliver_k only: go EMPTY. Outk keeps its last value (it is not cleared).
  - Neither event: hold.
- Latency: a word accepted in cycle N appears on Outk with Outk_Valid = 1 in cycle N+1.
- Ordering: words to the same destination are delivered in acceptance order. There is no ordering guarantee across destinations.
- Data is loaded only into the selected slot. The non-selected slot's data and valid are unaffected.
- Select = X or Z while In_Valid = 1 is a protocol violation. Out0 and Out1 are then both driven to X, matching the mux's default arm.
- Select is don't-care while In_Valid = 0. No state change occurs.
- Countk increments by 1 on each Deliver_k and wraps from all-ones to 0.
- Outk and Outk_Valid must remain stable while Outk_Valid = 1 and Outk_Ready = 0.
- Reset asserted mid-transfer: held words are discarded, both slots go EMPTY, and the counters clear immediately without waiting for Clock.
- After reset release: first acceptance is possible on the first rising edge with Reset_n high.

Decomposition:
- Shared package (ucd_digital_pkg) holds:
  - localparam SEL_OUT0 = 1'b0, SEL_OUT1 = 1'b1.
  - Default WIDTH 32.
- Sub-module demux_slot, instantiated twice, contains:
  - the one-entry register;
  - the valid flag;
  - the ready term;
  - the counter.
- The top level contains only the Select decode and the In_Ready select.

Test Plan:
- Reset: assert Reset_n = 0 mid-cycle with both slots full -> Out0_Valid = Out1_Valid = 0, Count0 = Count1 = 0, Out0 = Out1 = 0, with no clock edge required.
- Single routing: In = 32'hDEADBEEF, Select = 1, In_Valid = 1, Out1_Ready = 0 -> next cycle Out1 = DEADBEEF, Out1_Valid = 1, Out0_Valid = 0. Then Out1_Ready = 1 for one cycle -> Out1_Valid = 0, Count1 = 1.
- Independent stall:
  - Fill Out0 with 32'h11111111 while Out0_Ready = 0.
  - Then present Select = 0 -> In_Ready = 0.
  - Then present Select = 1 with 32'h22222222 -> In_Ready = 1, and Out1 = 22222222 next cycle.
  - Out0 stays 11111111 throughout.
- Back-to-back throughput: 8 words 0..7 to Out0 with Out0_Ready = 1 constantly -> In_Ready stays 1 every cycle, Out0 presents 0..7 on consecutive cycles, Count0 = 8.
- Simultaneous load and drain: slot 1 full with 32'hA5A5A5A5, Out1_Ready = 1, Select = 1, In = 32'h5A5A5A5A -> Out1 = 5A5A5A5A next cycle, Out1_Valid stays 1, Count1 increments by 1.
- Counter wrap: with CNT_WIDTH = 8, deliver 256 words on Out0 -> Count0 returns to 0. A further delivery gives Count0 = 1, and Count1 is unchanged.
